switch_debounce: RTL and testbench
==================================

Name: switch_debounce

Overview:
- Upstream conditioning stage for the slide-switch PIO input port. Takes raw asynchronous DE10 switch pins and synchronizes each bit into the clk domain, then debounces each bit independently.
- Drives a clean, stable WIDTH-bit vector into the PIO in_port.
- Also emits single-cycle per-bit rise/fall pulses and a combined change strobe. Game-of-life control logic can use these (pause/step/clear) without polling.

Parameters:
- WIDTH, 10: number of switch bits.
- DEBOUNCE_CYCLES, 50000: stable-mismatch cycles required before a bit updates (1 ms at 50 MHz). Legal range is 2 or more.
- CNT_W, 16: per-bit counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- sw_raw  input  WIDTH  raw switch pins; asynchronous to clk, may bounce.
- sw_stable  output  WIDTH  debounced switch state; connects to PIO in_port.
- sw_rise  output  WIDTH  one-cycle pulse per bit on a stable 0->1 transition.
- sw_fall  output  WIDTH  one-cycle pulse per bit on a stable 1->0 transition.
- sw_changed  output  1  one-cycle pulse, equal to OR of (sw_rise | sw_fall).

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values, while reset_n=0:
  - sync stage 1, sync stage 2, sw_stable, all counters, sw_rise, sw_fall and sw_changed are all 0.
  - Asynchronous assertion; release is sampled on the clk edge.
- Synchronizer: two flip-flops per bit (s1 <= sw_raw; s2 <= s1). No logic between them.
- Per-bit debounce, evaluated on each edge for bit i:
  - If s2[i] == sw_stable[i]: cnt[i] <= 0; no change.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1:
    - sw_stable[i] <= s2[i] and cnt[i] <= 0.
    - sw_rise[i] <= s2[i]; sw_fall[i] <= ~s2[i].
  - Else: cnt[i] <= cnt[i]+1.
- Pulse outputs:
  - sw_rise, sw_fall and sw_changed are registered. They are high for exactly one cycle, aligned with the cycle in which sw_stable first shows the new value. Otherwise they are 0.
- Latency: if sw_raw[i] changes and then holds, sw_stable[i] updates on the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new raw value into s1.
- Glitch rejection:
  - Any return of s2[i] to sw_stable[i] before the count completes clears cnt[i]; the stable value does not change.
  - A bounce train therefore restarts the count from zero.
- Independence: bits never share counters. Simultaneous transitions on several bits each complete on their own schedule. Same-cycle completions produce multiple set bits in sw_rise/sw_fall and a single sw_changed pulse.
- Counter arithmetic:
  - cnt never exceeds DEBOUNCE_CYCLES-1.
  - No wrap-around is possible, because it clears on match or on completion.
- Power-up / after reset: stable starts at 0. A switch already held high produces a normal 0->1 debounce (rise pulse DEBOUNCE_CYCLES+2 edges after reset release). This is intentional so that software sees the initial state via both polling and edge.
- Reset mid-count: all in-progress counts are discarded and pulses drop immediately.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=10):
- Reset: hold reset_n=0 with sw_raw=10'h3FF. Required: all outputs 0. Release reset; sw_raw held. Required: sw_stable=10'h3FF and sw_rise=10'h3FF for one cycle on the 6th edge after release; sw_changed=1 for that cycle only.
- Clean change: from stable 0, set sw_raw[3]=1 and hold. Required: sw_stable=10'h008 on the 6th edge; sw_rise=10'h008 and sw_changed=1 for one cycle; sw_fall=0.
- Bounce rejection: toggle sw_raw[0] 0->1->0 with 3-cycle high widths, repeated 5 times, then hold 0. Required: sw_stable[0] stays 0; no pulses.
- Bounce then settle: sw_raw[5] bounces 1/0 at 2-cycle intervals, then holds 1. Required: sw_stable[5]=1 exactly 6 edges after the final 0->1 raw edge; exactly one rise pulse.
- Simultaneous: with sw_stable=10'h001, set sw_raw=10'h200 in one cycle. Required: on the same edge, sw_stable=10'h200, sw_rise=10'h200, sw_fall=10'h001, with a single sw_changed pulse.
- Reset mid-count: start a 0->1 on bit 2 and assert reset_n=0 after 3 edges. Required: outputs 0 immediately. After release with raw held 1, a full 6-edge latency occurs before sw_stable[2]=1.

Source files
------------

// File: rtl/switch_debounce.sv
// Slide-switch input conditioning: two-flop synchronizer plus an independent
// debounce counter per bit, with registered rise/fall pulses and a change strobe.
module switch_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_s1;
  logic [WIDTH-1:0] sync_s2;

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  logic [WIDTH-1:0] stable_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Plain flop-to-flop path so the pair can be constrained as a synchronizer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_s1 <= '0;
      sync_s2 <= '0;
    end else begin
      sync_s1 <= sw_raw;
      sync_s2 <= sync_s1;
    end
  end

  // A bit updates only after DEBOUNCE_CYCLES consecutive mismatching samples;
  // any sample matching the stable value restarts the count.
  always_comb begin
    stable_d = sw_stable;
    rise_d   = '0;
    fall_d   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync_s2[i] != sw_stable[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync_s2[i];
          rise_d[i]   = sync_s2[i];
          fall_d[i]   = ~sync_s2[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pulses are registered alongside sw_stable so they coincide with the new value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sw_stable  <= '0;
      sw_rise    <= '0;
      sw_fall    <= '0;
      sw_changed <= 1'b0;
    end else begin
      sw_stable  <= stable_d;
      sw_rise    <= rise_d;
      sw_fall    <= fall_d;
      sw_changed <= |(rise_d | fall_d);
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4: a held raw change
// must appear on sw_stable on the 6th edge after it is applied.
module tb_switch_debounce;

  localparam int WIDTH = 10;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] sw_stable;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             sw_changed;

  int vectors;
  int miscompares;
  int rise5_cnt;

  switch_debounce #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic quiet(input string tag, input int n, input logic [WIDTH-1:0] stable_exp);
    for (int k = 0; k < n; k++) begin
      tick(1);
      chk({tag, "_stable"}, 32'(sw_stable), 32'(stable_exp));
      chk({tag, "_changed"}, 32'(sw_changed), 32'd0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rise5_cnt   = 0;
    reset_n     = 1'b0;
    sw_raw      = 10'h3FF;

    // Reset with every switch already high
    tick(3);
    chk("rst_stable", 32'(sw_stable), 32'h0);
    chk("rst_rise", 32'(sw_rise), 32'h0);
    chk("rst_fall", 32'(sw_fall), 32'h0);
    chk("rst_changed", 32'(sw_changed), 32'h0);
    reset_n = 1'b1;
    quiet("pwr", 5, 10'h000);
    tick(1);
    chk("pwr_stable", 32'(sw_stable), 32'h3FF);
    chk("pwr_rise", 32'(sw_rise), 32'h3FF);
    chk("pwr_fall", 32'(sw_fall), 32'h0);
    chk("pwr_changed", 32'(sw_changed), 32'h1);
    tick(1);
    chk("pwr_rise_end", 32'(sw_rise), 32'h0);
    chk("pwr_changed_end", 32'(sw_changed), 32'h0);
    chk("pwr_stable_hold", 32'(sw_stable), 32'h3FF);

    // All switches back low
    sw_raw = 10'h000;
    quiet("all_fall", 5, 10'h3FF);
    tick(1);
    chk("all_fall_stable", 32'(sw_stable), 32'h0);
    chk("all_fall_fall", 32'(sw_fall), 32'h3FF);
    chk("all_fall_changed", 32'(sw_changed), 32'h1);

    // Clean change on bit 3
    sw_raw = 10'h008;
    quiet("clean", 5, 10'h000);
    tick(1);
    chk("clean_stable", 32'(sw_stable), 32'h008);
    chk("clean_rise", 32'(sw_rise), 32'h008);
    chk("clean_fall", 32'(sw_fall), 32'h0);
    chk("clean_changed", 32'(sw_changed), 32'h1);
    tick(1);
    chk("clean_rise_end", 32'(sw_rise), 32'h0);
    chk("clean_changed_end", 32'(sw_changed), 32'h0);

    // Bit 0 bounces with 3-cycle highs, never long enough to qualify
    for (int r = 0; r < 5; r++) begin
      sw_raw = 10'h009;
      quiet("bounce_hi", 3, 10'h008);
      sw_raw = 10'h008;
      quiet("bounce_lo", 3, 10'h008);
    end
    quiet("bounce_hold", 8, 10'h008);
    chk("bounce_rise", 32'(sw_rise), 32'h0);

    // Bit 5 bounces at 2-cycle intervals, then settles high
    for (int r = 0; r < 3; r++) begin
      sw_raw = 10'h028;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        if (sw_rise[5]) rise5_cnt++;
      end
      sw_raw = 10'h008;
      for (int k = 0; k < 2; k++) begin
        tick(1);
        if (sw_rise[5]) rise5_cnt++;
      end
    end
    sw_raw = 10'h028;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      if (sw_rise[5]) rise5_cnt++;
      chk("settle_wait_stable", 32'(sw_stable), 32'h008);
    end
    tick(1);
    if (sw_rise[5]) rise5_cnt++;
    chk("settle_stable", 32'(sw_stable), 32'h028);
    chk("settle_rise", 32'(sw_rise), 32'h020);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      if (sw_rise[5]) rise5_cnt++;
    end
    chk("settle_rise_count", 32'(rise5_cnt), 32'd1);

    // Reach stable 001, then swap bit 0 for bit 9 in one cycle
    sw_raw = 10'h001;
    tick(6);
    chk("sim_setup_stable", 32'(sw_stable), 32'h001);
    tick(1);
    sw_raw = 10'h200;
    quiet("sim", 5, 10'h001);
    tick(1);
    chk("sim_stable", 32'(sw_stable), 32'h200);
    chk("sim_rise", 32'(sw_rise), 32'h200);
    chk("sim_fall", 32'(sw_fall), 32'h001);
    chk("sim_changed", 32'(sw_changed), 32'h1);
    tick(1);
    chk("sim_changed_end", 32'(sw_changed), 32'h0);
    chk("sim_fall_end", 32'(sw_fall), 32'h0);

    // Reset three edges into a bit-2 rise; asynchronous assertion clears outputs
    sw_raw = 10'h204;
    tick(3);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_stable", 32'(sw_stable), 32'h0);
    chk("midrst_rise", 32'(sw_rise), 32'h0);
    chk("midrst_fall", 32'(sw_fall), 32'h0);
    chk("midrst_changed", 32'(sw_changed), 32'h0);
    tick(2);
    reset_n = 1'b1;
    quiet("midrst_relat", 5, 10'h000);
    tick(1);
    chk("midrst_relat_stable", 32'(sw_stable), 32'h204);
    chk("midrst_relat_rise", 32'(sw_rise), 32'h204);
    chk("midrst_relat_changed", 32'(sw_changed), 32'h1);

    // Reset while pulses are high drops them at once
    #1 reset_n = 1'b0;
    #1;
    chk("pulserst_rise", 32'(sw_rise), 32'h0);
    chk("pulserst_changed", 32'(sw_changed), 32'h0);
    chk("pulserst_stable", 32'(sw_stable), 32'h0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
